wishbone_burst_master: RTL and testbench
========================================

// Module: wishbone_burst_master
// PURPOSE
//  Parametrised Wishbone B4 classic master with incrementing bursts (CTI/BTE), per-beat write/read streams,
//  bounded retry with backoff, and a bus timeout. Sits between a DMA/user engine and the Wishbone
//  interconnect; one command (1..MAX_BURST beats) is in flight at a time; status is reported once per command.
// PARAMETERS
//  ADDR_WIDTH      32  byte address width
//  DATA_WIDTH      32  data width (multiple of 8)
//  SEL_WIDTH       DATA_WIDTH/8  byte-select width
//  MAX_BURST       16  max beats per command (power of 2, >=2); LEN_W = clog2(MAX_BURST)
//  MAX_RETRY       8   rty responses tolerated per command before giving up (1..255)
//  BACKOFF_CYCLES  4   idle cycles (cyc low) between rty and re-issue (>=1)
//  TIMEOUT_CYCLES  256 cycles stb may stay high with no ack/err/rty before abort; 0 disables
// PORTS
//  clk         in   1           clock
//  rst         in   1           synchronous active-high reset
//  cmd_valid   in   1           command request
//  cmd_ready   out  1           command accepted when cmd_valid&&cmd_ready
//  cmd_we      in   1           1=write, 0=read
//  cmd_addr    in   ADDR_WIDTH  start byte address (beat aligned)
//  cmd_len     in   LEN_W       beats minus 1
//  cmd_sel     in   SEL_WIDTH   byte selects, all beats
//  wr_data     in   DATA_WIDTH  write beat data
//  wr_valid    in   1           write beat offered
//  wr_ready    out  1           write beat taken when wr_valid&&wr_ready
//  rd_data     out  DATA_WIDTH  read beat data
//  rd_valid    out  1           one-cycle pulse per read beat (no backpressure)
//  rd_last     out  1           with rd_valid on final beat
//  rsp_valid   out  1           one-cycle pulse at command end
//  rsp_status  out  2           00 OK, 01 ERR, 10 RETRY_EXHAUSTED, 11 TIMEOUT; held until next rsp
//  wb_adr_o/wb_dat_o/wb_sel_o/wb_we_o/wb_cyc_o/wb_stb_o  out  Wishbone request, registered
//  wb_cti_o    out  3           010 incrementing, 111 end of burst, 000 single
//  wb_bte_o    out  2           always 00 (linear)
//  wb_dat_i/wb_ack_i/wb_err_i/wb_rty_i  in  Wishbone response
// BEHAVIOUR
//  Reset: every output 0 (cmd_ready=0 during reset, 1 the cycle after); state IDLE; counters cleared.
//  States: IDLE -> BURST -> (BACKOFF -> BURST)* -> RESP -> IDLE.
//  IDLE: cmd_ready=1; on accept latch addr/len/sel/we, beat=0, retry_cnt=0; next cycle cyc=1 (BURST).
//  BURST read: stb=1 from first BURST cycle. Write: wr_ready=1 only while beat register empty;
//   on accept load wb_dat_o, stb=1 next cycle; cyc stays high while waiting for data (master wait state).
//  Response priority same cycle: ack > err > rty. Sampled only while stb=1.
//  ack: beat++, adr += SEL_WIDTH (wraps modulo 2^ADDR_WIDTH); read: rd_data<=wb_dat_i, rd_valid pulse
//   next cycle. Last beat: cyc/stb drop next cycle, RESP status OK. Otherwise stb continues (reads: back-to-back).
//  cti: len==0 -> 000; else 010 for beats < len, 111 on beat==len.
//  err: cyc/stb drop next cycle, RESP status ERR; remaining beats abandoned; no rd_valid for errored beat.
//  rty: retry_cnt++; if new count==MAX_RETRY -> RESP RETRY_EXHAUSTED, else BACKOFF: cyc/stb low
//   BACKOFF_CYCLES cycles, then re-issue from the same beat (same adr, held write data; no new wr handshake).
//   retry_cnt is per command, not reset by intervening acks.
//  Timeout: counter runs while stb=1, clears on any ack/err/rty; reaching TIMEOUT_CYCLES -> RESP TIMEOUT.
//  RESP: one cycle, rsp_valid=1, cyc=stb=0; then IDLE. Min command-to-command gap = 1 idle cycle.
//  Reset mid-command: bus released next edge, no rsp_valid, no rd_valid; wr beat held is discarded.
//  wb_we_o/wb_sel_o stay constant for the whole command including retries.
// TESTING
//  Single write addr 0x100 data 0xDEADBEEF sel 0xF, ack after 2 waits -> cti 000, one wr handshake, rsp OK.
//  Read len=3 at 0x40, slave acks every cycle 0xA0..0xA3 -> adr 40,44,48,4C; cti 010x3 then 111;
//   4 rd_valid, rd_last on 0xA3, rsp OK.
//  Write len=1, rty on beat 1 twice then ack -> 2x BACKOFF of 4 idle cycles, adr 0x..4 re-issued, rsp OK.
//  MAX_RETRY=8, slave always rty -> 8 attempts, then rsp RETRY_EXHAUSTED, cyc low.
//  Read len=7, err on beat 2 -> 2 rd_valid, no rd_last, rsp ERR; TIMEOUT_CYCLES=16 silent slave -> rsp TIMEOUT at 16.
//  Write len=3 with wr_valid gaps, and rst asserted mid-burst -> stb low during gaps with cyc high; after rst all outputs 0.

Source files
------------

// File: rtl/wishbone_burst_master.sv
// Wishbone B4 classic master issuing incrementing bursts of 1..MAX_BURST beats, one command at a time,
// with bounded retry/backoff on rty and a stb timeout; one status pulse per command.
module wishbone_burst_master #(
    parameter int  ADDR_WIDTH     = 32,
    parameter int  DATA_WIDTH     = 32,
    parameter int  SEL_WIDTH      = DATA_WIDTH / 8,
    parameter int  MAX_BURST      = 16,
    parameter int  MAX_RETRY      = 8,
    parameter int  BACKOFF_CYCLES = 4,
    parameter int  TIMEOUT_CYCLES = 256,
    localparam int LEN_W          = $clog2(MAX_BURST)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic [SEL_WIDTH-1:0]  cmd_sel,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    output logic                  rsp_valid,
    output logic [1:0]            rsp_status,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    output logic [SEL_WIDTH-1:0]  wb_sel_o,
    output logic                  wb_we_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic [2:0]            wb_cti_o,
    output logic [1:0]            wb_bte_o,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    input  logic                  wb_rty_i
);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_BACKOFF, S_RESP} state_t;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_ERR = 2'b01;
    localparam logic [1:0] ST_RTY = 2'b10;
    localparam logic [1:0] ST_TMO = 2'b11;

    localparam logic [2:0] CTI_SINGLE = 3'b000;
    localparam logic [2:0] CTI_INCR   = 3'b010;
    localparam logic [2:0] CTI_END    = 3'b111;

    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int BO_W  = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;
    localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [BO_W-1:0]       BO_LAST  = BO_W'(BACKOFF_CYCLES - 1);
    localparam logic [7:0]            RTY_LAST = 8'(MAX_RETRY - 1);
    localparam logic [ADDR_WIDTH-1:0] ADR_STEP = ADDR_WIDTH'(SEL_WIDTH);

    state_t           state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] beat;
    logic [7:0]       retry_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [BO_W-1:0]  bo_cnt;
    logic             last_beat;
    logic             tmo_hit;
    logic             done;
    logic [1:0]       done_status;

    function automatic logic [2:0] cti_for(input logic [LEN_W-1:0] b, input logic [LEN_W-1:0] l);
        if (l == '0) return CTI_SINGLE;
        return (b == l) ? CTI_END : CTI_INCR;
    endfunction

    assign wb_bte_o  = 2'b00;
    assign last_beat = (beat == len);
    assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);

    // Command termination this cycle; ack beats err beats rty, timeout only when the bus is silent.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        done        = 1'b0;
        done_status = ST_OK;
        if (state == S_BURST && wb_stb_o) begin
            if (wb_ack_i) begin
                done = last_beat;
            end else if (wb_err_i) begin
                done        = 1'b1;
                done_status = ST_ERR;
            end else if (wb_rty_i) begin
                done        = (retry_cnt == RTY_LAST);
                done_status = ST_RTY;
            end else if (tmo_hit) begin
                done        = 1'b1;
                done_status = ST_TMO;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        rd_valid  <= 1'b0;
        rd_last   <= 1'b0;
        rsp_valid <= 1'b0;
        if (rst) begin
            state      <= S_IDLE;
            cmd_ready  <= 1'b0;
            wr_ready   <= 1'b0;
            rd_data    <= '0;
            rsp_status <= ST_OK;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            wb_sel_o   <= '0;
            wb_we_o    <= 1'b0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_cti_o   <= CTI_SINGLE;
            len        <= '0;
            beat       <= '0;
            retry_cnt  <= '0;
            tmo_cnt    <= '0;
            bo_cnt     <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        state     <= S_BURST;
                        cmd_ready <= 1'b0;
                        len       <= cmd_len;
                        beat      <= '0;
                        retry_cnt <= '0;
                        tmo_cnt   <= '0;
                        wb_adr_o  <= cmd_addr;
                        wb_sel_o  <= cmd_sel;
                        wb_we_o   <= cmd_we;
                        wb_cyc_o  <= 1'b1;
                        wb_stb_o  <= !cmd_we;
                        wr_ready  <= cmd_we;
                        wb_cti_o  <= cti_for('0, cmd_len);
                    end
                end
                S_BURST: begin
                    if (wb_stb_o && wb_ack_i && !wb_we_o) begin
                        rd_valid <= 1'b1;
                        rd_data  <= wb_dat_i;
                        rd_last  <= last_beat;
                    end
                    if (done) begin
                        state      <= S_RESP;
                        rsp_valid  <= 1'b1;
                        rsp_status <= done_status;
                        wb_cyc_o   <= 1'b0;
                        wb_stb_o   <= 1'b0;
                        wb_cti_o   <= CTI_SINGLE;
                        wr_ready   <= 1'b0;
                    end else if (wb_stb_o && wb_ack_i) begin
                        tmo_cnt  <= '0;
                        beat     <= beat + 1'b1;
                        wb_adr_o <= wb_adr_o + ADR_STEP;
                        wb_cti_o <= cti_for(beat + 1'b1, len);
                        // Writes pause stb until the next beat's data is in the register.
                        wb_stb_o <= !wb_we_o;
                        wr_ready <= wb_we_o;
                    end else if (wb_stb_o && wb_rty_i) begin
                        tmo_cnt   <= '0;
                        retry_cnt <= retry_cnt + 8'd1;
                        bo_cnt    <= '0;
                        state     <= S_BACKOFF;
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                    end else if (wb_stb_o) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end else if (wr_valid && wr_ready) begin
                        wb_dat_o <= wr_data;
                        wr_ready <= 1'b0;
                        wb_stb_o <= 1'b1;
                    end
                end
                S_BACKOFF: begin
                    // Re-issue the same beat; a write beat is still held in wb_dat_o.
                    if (bo_cnt == BO_LAST) begin
                        state    <= S_BURST;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                    end else begin
                        bo_cnt <= bo_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wishbone_burst_master.sv
// Directed bench for wishbone_burst_master: scripted slave responses per attempt, hand-computed expectations.
module tb_wishbone_burst_master;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_ERR = 2'b01;
    localparam logic [1:0] ST_RTY = 2'b10;
    localparam logic [1:0] ST_TMO = 2'b11;

    typedef enum int {K_ACK, K_ERR, K_RTY} kind_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic [3:0]  cmd_sel;
    logic [31:0] wr_data;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid, rd_last, rsp_valid;
    logic [1:0]  rsp_status;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic        wb_ack_i, wb_err_i, wb_rty_i;

    always #5 clk = ~clk;

    wishbone_burst_master #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_BURST(16),
        .MAX_RETRY(8), .BACKOFF_CYCLES(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_sel(cmd_sel),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
        .rsp_valid(rsp_valid), .rsp_status(rsp_status),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Slave script (one entry per response) and write-data stream.
    kind_t       kinds[$];
    int          waits[$];
    logic [31:0] wq[$];
    int          wr_gap;

    // What one command looked like on the bus.
    logic [31:0] adr_log[$];
    logic [2:0]  cti_log[$];
    logic [31:0] dat_log[$];
    kind_t       kind_log[$];
    logic [31:0] rd_log[$];
    int          rd_last_cnt, rd_last_idx, wr_hs, cyc_low, stb_high, wait_state, attr_bad, cycles;
    logic        got_rsp;
    logic [1:0]  rsp_st;
    logic        exp_we;
    logic [3:0]  exp_sel;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] len, input logic [3:0] sel);
        int guard = 0;
        exp_we    = we;
        exp_sel   = sel;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_len   = len;
        cmd_sel   = sel;
        while (!cmd_ready && guard < 20) begin
            tick();
            guard++;
        end
        check("cmd_ready_wait", 64'(cmd_ready), 64'(1));
        tick();
        cmd_valid = 1'b0;
    endtask

    // Plays the slave script and the write stream until rsp_valid or the budget runs out.
    task automatic bus_run(input int budget);
        int   n = 0, waited = 0, widx = 0, gap = 0, acks = 0;
        logic hs;
        adr_log.delete(); cti_log.delete(); dat_log.delete(); kind_log.delete(); rd_log.delete();
        rd_last_cnt = 0; rd_last_idx = -1; wr_hs = 0; cyc_low = 0; stb_high = 0;
        wait_state = 0; attr_bad = 0; cycles = 0; got_rsp = 1'b0; rsp_st = 2'bxx;
        for (int c = 0; c < budget && !got_rsp; c++) begin
            wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = '0;
            wr_valid = (widx < wq.size()) && (gap == 0);
            wr_data  = wr_valid ? wq[widx] : '0;
            hs       = wr_valid && wr_ready;
            if (!wr_valid && wr_ready && gap > 0) gap--;
            if (!wb_cyc_o) cyc_low++;
            else begin
                if (!wb_stb_o) wait_state++;
                if (wb_we_o !== exp_we || wb_sel_o !== exp_sel) attr_bad++;
            end
            if (wb_stb_o) begin
                stb_high++;
                if (n < kinds.size()) begin
                    if (waited == waits[n]) begin
                        adr_log.push_back(wb_adr_o);
                        cti_log.push_back(wb_cti_o);
                        dat_log.push_back(wb_dat_o);
                        kind_log.push_back(kinds[n]);
                        case (kinds[n])
                            K_ACK: begin wb_ack_i = 1'b1; wb_dat_i = 32'hA0 + acks; acks++; end
                            K_ERR: wb_err_i = 1'b1;
                            K_RTY: wb_rty_i = 1'b1;
                            default: ;
                        endcase
                        n++;
                        waited = 0;
                    end else begin
                        waited++;
                    end
                end
            end
            tick();
            cycles++;
            if (hs) begin widx++; gap = wr_gap; wr_hs++; end
            if (rd_valid) begin
                rd_log.push_back(rd_data);
                if (rd_last) begin rd_last_cnt++; rd_last_idx = rd_log.size() - 1; end
            end
            if (rsp_valid) begin got_rsp = 1'b1; rsp_st = rsp_status; end
        end
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wr_valid = 1'b0;
        check("rsp_within_budget", 64'(got_rsp), 64'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_sel = '0;
        wr_data = '0; wr_valid = 1'b0; wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
        wr_gap = 0;

        // Reset state
        repeat (3) tick();
        check("rst_cyc_stb", 64'({wb_cyc_o, wb_stb_o}), 64'(0));
        check("rst_handshakes", 64'({cmd_ready, wr_ready, rd_valid, rsp_valid}), 64'(0));
        check("rst_bus_attr", 64'({wb_adr_o, wb_cti_o, wb_bte_o, wb_we_o, wb_sel_o}), 64'(0));
        rst = 1'b0;
        tick();
        check("cmd_ready_after_rst", 64'(cmd_ready), 64'(1));

        // Single write, ack after 2 wait states
        kinds = '{K_ACK}; waits = '{2}; wq = '{32'hDEADBEEF}; wr_gap = 0;
        issue(1'b1, 32'h100, 4'd0, 4'hF);
        check("wr1_first_cycle", 64'({wb_cyc_o, wb_stb_o, wr_ready}), 64'(3'b101));
        check("wr1_cti", 64'(wb_cti_o), 64'(3'b000));
        bus_run(20);
        check("wr1_beats", 64'(adr_log.size()), 64'(1));
        check("wr1_adr", 64'(adr_log[0]), 64'(32'h100));
        check("wr1_data", 64'(dat_log[0]), 64'(32'hDEADBEEF));
        check("wr1_wr_handshakes", 64'(wr_hs), 64'(1));
        check("wr1_stb_cycles", 64'(stb_high), 64'(3));
        check("wr1_status", 64'(rsp_st), 64'(ST_OK));
        check("wr1_cyc_released", 64'({wb_cyc_o, wb_stb_o}), 64'(0));
        check("wr1_we_sel_const", 64'(attr_bad), 64'(0));
        check("resp_cycle_not_ready", 64'(cmd_ready), 64'(0));

        // Read len=3 at 0x40, ack every cycle
        kinds = '{K_ACK, K_ACK, K_ACK, K_ACK}; waits = '{0, 0, 0, 0}; wq.delete();
        issue(1'b0, 32'h40, 4'd3, 4'hF);
        check("rd4_first_cycle", 64'({wb_cyc_o, wb_stb_o, wb_cti_o}), 64'(5'b11010));
        bus_run(20);
        check("rd4_beats", 64'(adr_log.size()), 64'(4));
        for (int i = 0; i < 4; i++) begin
            check("rd4_adr", 64'(adr_log[i]), 64'(32'h40 + 4 * i));
            check("rd4_cti", 64'(cti_log[i]), 64'((i == 3) ? 3'b111 : 3'b010));
            check("rd4_data", 64'(rd_log[i]), 64'(32'hA0 + i));
        end
        check("rd4_rd_count", 64'(rd_log.size()), 64'(4));
        check("rd4_last", 64'({rd_last_cnt[3:0], rd_last_idx[3:0]}), 64'(8'h13));
        check("rd4_back_to_back", 64'(cycles), 64'(4));
        check("rd4_status", 64'(rsp_st), 64'(ST_OK));

        // Write len=1, rty twice on beat 1 then ack
        kinds = '{K_ACK, K_RTY, K_RTY, K_ACK}; waits = '{0, 0, 0, 0};
        wq = '{32'h11111111, 32'h22222222};
        issue(1'b1, 32'h200, 4'd1, 4'h3);
        bus_run(60);
        check("rty2_attempts", 64'(adr_log.size()), 64'(4));
        check("rty2_adr", 64'({adr_log[0], adr_log[3]}), {32'h200, 32'h204});
        check("rty2_reissue_adr", 64'({adr_log[1], adr_log[2]}), {32'h204, 32'h204});
        check("rty2_held_data", 64'({dat_log[2], dat_log[3]}), {32'h22222222, 32'h22222222});
        check("rty2_cti", 64'({cti_log[0], cti_log[1], cti_log[3]}), 64'(9'b010_111_111));
        check("rty2_backoff_cycles", 64'(cyc_low), 64'(8));
        check("rty2_wr_handshakes", 64'(wr_hs), 64'(2));
        check("rty2_we_sel_const", 64'(attr_bad), 64'(0));
        check("rty2_status", 64'(rsp_st), 64'(ST_OK));

        // Slave always rty: exhausted after MAX_RETRY=8 attempts
        kinds.delete(); waits.delete(); wq.delete();
        for (int i = 0; i < 10; i++) begin kinds.push_back(K_RTY); waits.push_back(0); end
        issue(1'b0, 32'h300, 4'd0, 4'hF);
        bus_run(100);
        check("rtyx_attempts", 64'(kind_log.size()), 64'(8));
        check("rtyx_backoff_cycles", 64'(cyc_low), 64'(28));
        check("rtyx_status", 64'(rsp_st), 64'(ST_RTY));
        check("rtyx_cyc_low", 64'({wb_cyc_o, wb_stb_o}), 64'(0));
        check("rtyx_no_rd", 64'(rd_log.size()), 64'(0));
        tick();
        check("rtyx_status_held", 64'({rsp_valid, rsp_status}), 64'({1'b0, ST_RTY}));

        // Read len=7, err on beat 2
        kinds = '{K_ACK, K_ACK, K_ERR}; waits = '{0, 0, 1};
        issue(1'b0, 32'h500, 4'd7, 4'hF);
        bus_run(30);
        check("err_rd_count", 64'(rd_log.size()), 64'(2));
        check("err_rd_data", 64'({rd_log[0], rd_log[1]}), {32'hA0, 32'hA1});
        check("err_no_rd_last", 64'(rd_last_cnt), 64'(0));
        check("err_adr", 64'(adr_log[2]), 64'(32'h508));
        check("err_status", 64'(rsp_st), 64'(ST_ERR));
        check("err_cyc_low", 64'(wb_cyc_o), 64'(0));

        // Silent slave: timeout after 16 stb cycles
        kinds.delete(); waits.delete();
        issue(1'b0, 32'h600, 4'd0, 4'hF);
        bus_run(40);
        check("tmo_stb_cycles", 64'(stb_high), 64'(16));
        check("tmo_cycles", 64'(cycles), 64'(16));
        check("tmo_status", 64'(rsp_st), 64'(ST_TMO));

        // Reset in the middle of a write burst, with beat 1 held
        tick();
        issue(1'b1, 32'h800, 4'd3, 4'h3);
        wr_valid = 1'b1; wr_data = 32'h55;
        tick();
        wr_valid = 1'b0;
        check("mid_beat0_stb", 64'({wb_cyc_o, wb_stb_o, wb_dat_o}), 64'({2'b11, 32'h55}));
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        wr_valid = 1'b1; wr_data = 32'h66;
        tick();
        wr_valid = 1'b0;
        check("mid_beat1_adr", 64'({wb_stb_o, wb_adr_o}), 64'({1'b1, 32'h804}));
        rst = 1'b1;
        tick();
        check("mid_rst_bus", 64'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_cti_o, wb_bte_o}), 64'(0));
        check("mid_rst_adr_dat", {wb_adr_o, wb_dat_o}, 64'(0));
        check("mid_rst_stream", 64'({cmd_ready, wr_ready, rd_valid, rd_last, rsp_valid, rsp_status}), 64'(0));
        rst = 1'b0;
        tick();
        check("mid_rst_ready", 64'({cmd_ready, rsp_valid}), 64'(2'b10));

        // Fresh write after reset: register empty, new data used
        kinds = '{K_ACK}; waits = '{0}; wq = '{32'h77};
        issue(1'b1, 32'h904, 4'd0, 4'hF);
        check("post_rst_wr_ready", 64'({wb_cyc_o, wb_stb_o, wr_ready}), 64'(3'b101));
        bus_run(20);
        check("post_rst_data", 64'({adr_log[0], dat_log[0]}), {32'h904, 32'h77});
        check("post_rst_status", 64'(rsp_st), 64'(ST_OK));

        // Write len=3 with 2-cycle gaps on wr_valid: stb low, cyc high meanwhile
        kinds = '{K_ACK, K_ACK, K_ACK, K_ACK}; waits = '{0, 0, 0, 0};
        wq = '{32'hC0, 32'hC1, 32'hC2, 32'hC3}; wr_gap = 2;
        issue(1'b1, 32'h700, 4'd3, 4'h5);
        bus_run(60);
        check("gap_wait_state_cycles", 64'(wait_state), 64'(10));
        check("gap_cyc_never_low", 64'(cyc_low), 64'(0));
        check("gap_wr_handshakes", 64'(wr_hs), 64'(4));
        for (int i = 0; i < 4; i++) begin
            check("gap_adr", 64'(adr_log[i]), 64'(32'h700 + 4 * i));
            check("gap_data", 64'(dat_log[i]), 64'(32'hC0 + i));
        end
        check("gap_cti_last", 64'(cti_log[3]), 64'(3'b111));
        check("gap_we_sel_const", 64'(attr_bad), 64'(0));
        check("gap_status", 64'(rsp_st), 64'(ST_OK));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
